// File: rtl/tt_um_brs_prbs_mc.sv
// Multi-channel PRBS generator/checker (BERT) in the Tiny Tapeout pinout; tx registered, checker error counts reported on uo_out.
// Optional BRS_LOOPBACK_EN: mode 11 runs with internal tx->rx loopback; otherwise mode 11 holds like mode 01.
module tt_um_brs_prbs_mc #(
    parameter int                LFSR_W     = 15,
    parameter logic [LFSR_W-1:0] TAPS       = 15'h6000,
    parameter logic [LFSR_W-1:0] SEED       = 15'h0001,
    parameter int                NUM_CH     = 4,
    parameter int                ERR_W      = 7,
    parameter int                LOCK_CNT   = 32,
    parameter int                UNLOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [7:0] OE_MASK = 8'(((1 << NUM_CH) - 1) << 4);
    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic       gen_en, chk_en, inject, clear;
    logic [1:0] rd_sel, mode;
    logic       inj_d, inj_pulse;
    logic       lfsr_run, lfsr_load, loop_sel;

    logic [NUM_CH-1:0]            tx_vec;
    logic [NUM_CH-1:0]            locked_vec;
    logic [NUM_CH-1:0][ERR_W-1:0] err_vec;
    logic [7:0]                   uo_nxt;
    logic                         unused_ok;

    assign gen_en = ui_in[0];
    assign chk_en = ui_in[1];
    assign inject = ui_in[2];
    assign clear  = ui_in[3];
    assign rd_sel = ui_in[5:4];
    assign mode   = ui_in[7:6];

    assign lfsr_load = (mode == 2'b10);
`ifdef BRS_LOOPBACK_EN
    assign loop_sel  = (mode == 2'b11);
    assign lfsr_run  = (mode == 2'b00) || loop_sel;
`else
    assign loop_sel  = 1'b0;
    assign lfsr_run  = (mode == 2'b00);
`endif

    assign inj_pulse = inject & ~inj_d;
    assign unused_ok = &{1'b0, uio_in, loop_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_d <= 1'b0;
        end else if (ena) begin
            inj_d <= inject;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [LFSR_W-1:0] SEED_C = SEED ^ LFSR_W'(c);

        logic [LFSR_W-1:0] lfsr;
        logic [LFSR_W-1:0] sr;
        logic              tx_r, s1, s2;
        logic              rx_raw, pred, mism, sr_zero;
        logic [0:0]        state;
        logic [RUN_W-1:0]  run_cnt;
        logic [MISS_W-1:0] miss_cnt;
        logic [ERR_W-1:0]  err;

`ifdef BRS_LOOPBACK_EN
        assign rx_raw = loop_sel ? tx_r : uio_in[c];
`else
        assign rx_raw = uio_in[c];
`endif
        assign pred    = ^(sr & TAPS);
        assign mism    = s2 ^ pred;
        assign sr_zero = (sr == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lfsr <= SEED_C;
                tx_r <= 1'b0;
            end else if (ena) begin
                tx_r <= lfsr[LFSR_W-1] ^ inj_pulse;
                if (lfsr_load) begin
                    lfsr <= SEED_C;
                end else if (lfsr_run && gen_en) begin
                    // A stuck all-zero register is kicked back into the sequence.
                    lfsr <= (lfsr == '0) ? LFSR_W'(1) : {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1       <= 1'b0;
                s2       <= 1'b0;
                sr       <= '0;
                state    <= SEARCH;
                run_cnt  <= '0;
                miss_cnt <= '0;
                err      <= '0;
            end else if (ena) begin
                s1 <= rx_raw;
                s2 <= s1;
                sr <= {sr[LFSR_W-2:0], s2};
                if (clear) begin
                    err <= '0;
                end else if (chk_en && (state == LOCKED) && mism && (err != {ERR_W{1'b1}})) begin
                    err <= err + 1'b1;
                end
                if (chk_en) begin
                    if (state == SEARCH) begin
                        // An empty register predicts zeros, so constant-0 input must not count as a match.
                        if (mism || sr_zero) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            run_cnt  <= '0;
                            miss_cnt <= '0;
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end else begin
                        if (!mism) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
                            state    <= SEARCH;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
            end
        end

        assign tx_vec[c]     = tx_r;
        assign locked_vec[c] = (state == LOCKED);
        assign err_vec[c]    = err;
    end

    always_comb begin
        uo_nxt = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_sel == 2'(c)) begin
                uo_nxt = {locked_vec[c], 7'(err_vec[c])};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out <= 8'h00;
        end else if (ena) begin
            uo_out <= uo_nxt;
        end
    end

    assign uio_out = {4'(tx_vec), 4'b0000};
    assign uio_oe  = OE_MASK;

endmodule

// File: tb/tb_tt_um_brs_prbs_mc.sv
// Directed bench for the multi-channel PRBS BERT: generator sequence, hold/reload, lock, inject, saturation, clear, reset.
module tb_tt_um_brs_prbs_mc;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic       gen_en, chk_en, inject, clear, tie;
    logic [1:0] rd_sel, mode;
    logic [7:0] ui_in, uio_in, uio_drv;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [14:0] m [4];
    logic [3:0]  expv;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ui_in  = {mode, rd_sel, clear, inject, chk_en, gen_en};
    assign uio_in = tie ? {4'b0000, uio_out[7:4]} : uio_drv;

    tt_um_brs_prbs_mc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // x^15 + x^14 + 1, shifting left, with the zero-state kick.
    function automatic logic [14:0] step(input logic [14:0] s);
        if (s == 15'd0) return 15'd1;
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    task automatic seed_models();
        for (int c = 0; c < 4; c++) m[c] = 15'h0001 ^ 15'(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seed_models();
    endtask

    task automatic test_reset();
        ena = 1'b1; gen_en = 0; chk_en = 0; inject = 0; clear = 0; tie = 0;
        rd_sel = 0; mode = 0; uio_drv = 8'h00;
        do_reset();
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo got %h exp 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h exp 00", uio_out); end
        checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL uio_oe got %h exp f0", uio_oe); end
    endtask

    task automatic test_gen();
        gen_en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 50; i++) begin
            for (int c = 0; c < 4; c++) begin expv[c] = m[c][14]; m[c] = step(m[c]); end
            @(negedge clk);
            checks++;
            if (uio_out !== {expv, 4'b0000}) begin
                errors++; $display("FAIL gen_bit%0d got %h exp %h", i, uio_out, {expv, 4'b0000});
            end
        end
    endtask

    task automatic test_hold();
        mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) expv[c] = m[c][14];
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL hold01 got %h exp %h", uio_out[7:4], expv); end
        end
`ifndef BRS_LOOPBACK_EN
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL hold11 got %h exp %h", uio_out[7:4], expv); end
        end
`endif
        mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 4; c++) begin expv[c] = m[c][14]; m[c] = step(m[c]); end
            @(negedge clk);
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL resume%0d got %h exp %h", i, uio_out[7:4], expv); end
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL ena_hold got %h exp %h", uio_out[7:4], expv); end
        end
        ena = 1'b1;
        mode = 2'b10;
        repeat (3) @(negedge clk);
        seed_models();
        mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 4; c++) begin expv[c] = m[c][14]; m[c] = step(m[c]); end
            @(negedge clk);
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL reload%0d got %h exp %h", i, uio_out[7:4], expv); end
        end
    endtask

    task automatic wait_all_locked(input string tag);
        int n;
        rd_sel = 2'd0;
        n = 0;
        while (uo_out[7] !== 1'b1 && n < 51) begin
            @(negedge clk);
            n++;
        end
        checks++; if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL %s_lock_ch0 got %b exp 1", tag, uo_out[7]); end
        for (int s = 1; s < 4; s++) begin
            rd_sel = 2'(s);
            @(negedge clk);
            checks++; if (uo_out[7] !== 1'b1) begin errors++; $display("FAIL %s_lock_ch%0d got %b exp 1", tag, s, uo_out[7]); end
        end
        repeat (1000) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            @(negedge clk);
            checks++; if (uo_out !== 8'h80) begin errors++; $display("FAIL %s_clean_ch%0d got %h exp 80", tag, s, uo_out); end
        end
    endtask

    task automatic test_lock();
        do_reset();
        tie = 1'b1; gen_en = 1'b1; chk_en = 1'b1; mode = 2'b00;
        wait_all_locked("loop");
    endtask

    task automatic pulse_inject(input int gap);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic test_inject();
        for (int k = 0; k < 3; k++) pulse_inject(50);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            @(negedge clk);
            checks++; if (uo_out !== 8'h89) begin errors++; $display("FAIL inject3_ch%0d got %h exp 89", s, uo_out); end
        end
    endtask

    task automatic test_saturate_clear();
        for (int k = 0; k < 50; k++) pulse_inject(40);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            @(negedge clk);
            checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL sat_ch%0d got %h exp ff", s, uo_out); end
        end
        rd_sel = 2'd0;
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checks++; if (uo_out !== 8'h80) begin errors++; $display("FAIL clear_vs_err got %h exp 80", uo_out); end
        repeat (40) @(negedge clk);
        checks++; if (uo_out !== 8'h82) begin errors++; $display("FAIL after_clear got %h exp 82", uo_out); end
    endtask

    task automatic test_reset_midrun();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL midrst_uo got %h exp 00", uo_out); end
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL midrst_uio got %h exp 00", uio_out); end
        @(negedge clk);
        rst_n = 1'b1;
        seed_models();
        tie = 1'b0; uio_drv = 8'h00;
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < 4; c++) begin expv[c] = m[c][14]; m[c] = step(m[c]); end
            @(negedge clk);
            checks++; if (uio_out[7:4] !== expv) begin errors++; $display("FAIL restart%0d got %h exp %h", i, uio_out[7:4], expv); end
        end
    endtask

    task automatic test_no_signal();
        do_reset();
        tie = 1'b0; uio_drv = 8'h00; gen_en = 1'b1; chk_en = 1'b1; mode = 2'b00;
        repeat (1000) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            @(negedge clk);
            checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL zero_in_ch%0d got %h exp 00", s, uo_out); end
        end
    endtask

`ifdef BRS_LOOPBACK_EN
    task automatic test_loopback();
        do_reset();
        tie = 1'b0; uio_drv = 8'h00; gen_en = 1'b1; chk_en = 1'b1; mode = 2'b11;
        wait_all_locked("intlb");
    endtask
`endif

    initial begin
        test_reset();
        test_gen();
        test_hold();
        test_lock();
        test_inject();
        test_saturate_clear();
        test_reset_midrun();
        test_no_signal();
`ifdef BRS_LOOPBACK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
